// File: rtl/qseq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qseq_pkg                                                                   |
// | Shared types and constants for the query sequencer.                        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package qseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [31:0] SYNC_WORD = 32'hFFFF_FFFF;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BAD_K    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

endpackage
`default_nettype wire

// File: rtl/qseq_result_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qseq_result_buf                                                            |
// | K_MAX x 32 result register file: append-only write, clear, registered read.|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module qseq_result_buf #(
    parameter int K_MAX = 8,
    parameter int CW    = $clog2(K_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_wr_en,
    input  logic [31:0]   i_wr_data,
    input  logic          i_rd_en,
    input  logic [CW-1:0] i_rd_addr,
    output logic [31:0]   o_rd_data,
    output logic [CW-1:0] o_count
);

    localparam int            AW      = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam logic [CW-1:0] c_k_max = CW'(K_MAX);

    logic [31:0]   r_mem [K_MAX];
    logic [CW-1:0] r_count;
    logic [31:0]   r_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K_MAX; i++) begin
                r_mem[i] <= '0;
            end
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (i_clr) begin
                r_count <= '0;
            end else if (i_wr_en && (r_count < c_k_max)) begin
                r_mem[r_count[AW-1:0]] <= i_wr_data;
                r_count                <= r_count + 1'b1;
            end
            // Addresses past the captured count read as zero.
            if (i_rd_en && (i_rd_addr < r_count)) begin
                r_rd_data <= r_mem[i_rd_addr[AW-1:0]];
            end else begin
                r_rd_data <= '0;
            end
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_count   = r_count;

endmodule
`default_nettype wire

// File: rtl/query_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | query_sequencer                                                            |
// | Loads a query from the host mailbox, launches the search engine, times it  |
// | and serves captured results. Define QSEQ_TIMEOUT_EN for the RUN watchdog.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module query_sequencer
    import qseq_pkg::*;
#(
    parameter int          DIM            = 4,
    parameter int          K_MAX          = 8,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
    localparam int         CW             = $clog2(K_MAX + 1)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic [31:0]   host_word_in,
    input  logic          host_tag_in,
    input  logic          host_rd_tag_in,
    output logic [31:0]   eng_query_out [DIM],
    output logic [15:0]   eng_k_out,
    output logic [31:0]   eng_vid_out,
    output logic          eng_start_out,
    input  logic [31:0]   eng_result_in,
    input  logic          eng_result_valid_in,
    input  logic          eng_done_in,
    output logic [31:0]   res_data_out,
    output logic [CW-1:0] res_count_out,
    output logic [31:0]   cycles_out,
    output logic          busy_out,
    output logic          done_out,
    output logic [1:0]    err_out
);

    localparam int          IW        = $clog2(DIM + 2);
    localparam logic [IW-1:0] c_idx_k = IW'(DIM);
    localparam logic [15:0] c_k_max   = 16'(K_MAX);
`ifdef QSEQ_TIMEOUT_EN
    localparam logic        c_wdog_en = 1'b1;
`else
    localparam logic        c_wdog_en = 1'b0;
`endif

    state_t        r_state;
    logic          r_init;
    logic          r_tag_q, r_tag_prev, r_rd_q, r_rd_prev;
    logic [31:0]   r_word_q;
    logic [IW-1:0] r_idx;
    logic [31:0]   r_coord [DIM];
    logic [15:0]   r_k_shadow;
    logic [CW-1:0] r_rd_ptr;

    logic        w_accept, w_rd_accept, w_sync, w_k_bad;
    logic        w_res_run, w_has_room, w_buf_wr, w_res_drop, w_buf_clr;
    logic        w_timeout_hit;
    logic [31:0] w_cycles_next;

    assign w_accept      = r_init && (r_tag_q != r_tag_prev);
    assign w_rd_accept   = r_init && (r_rd_q != r_rd_prev);
    assign w_sync        = w_accept && (r_word_q == SYNC_WORD);
    assign w_k_bad       = (r_k_shadow == 16'd0) || (r_k_shadow > c_k_max);
    assign w_res_run     = (r_state == ST_RUN) && eng_result_valid_in;
    assign w_has_room    = 16'(res_count_out) < eng_k_out;
    assign w_buf_wr      = w_res_run && w_has_room;
    assign w_res_drop    = w_res_run && !w_has_room;
    assign w_buf_clr     = (r_state == ST_LAUNCH) || ((r_state == ST_DONE) && w_sync);
    assign w_cycles_next = (cycles_out == 32'hFFFF_FFFF) ? cycles_out : cycles_out + 32'd1;
    assign w_timeout_hit = c_wdog_en && (w_cycles_next >= TIMEOUT_CYCLES);

    qseq_result_buf #(
        .K_MAX (K_MAX),
        .CW    (CW)
    ) u_buf (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .i_clr     (w_buf_clr),
        .i_wr_en   (w_buf_wr),
        .i_wr_data (eng_result_in),
        .i_rd_en   (r_state == ST_DONE),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (res_data_out),
        .o_count   (res_count_out)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= ST_IDLE;
            r_init        <= 1'b0;
            r_tag_q       <= 1'b0;
            r_tag_prev    <= 1'b0;
            r_rd_q        <= 1'b0;
            r_rd_prev     <= 1'b0;
            r_word_q      <= '0;
            r_idx         <= '0;
            r_k_shadow    <= '0;
            r_rd_ptr      <= '0;
            for (int i = 0; i < DIM; i++) begin
                r_coord[i]       <= '0;
                eng_query_out[i] <= '0;
            end
            eng_k_out     <= '0;
            eng_vid_out   <= '0;
            eng_start_out <= 1'b0;
            cycles_out    <= '0;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
            err_out       <= ERR_NONE;
        end else begin
            // First clock after reset seeds both tag stages from the live input.
            r_init        <= 1'b1;
            r_tag_q       <= host_tag_in;
            r_tag_prev    <= r_init ? r_tag_q : host_tag_in;
            r_rd_q        <= host_rd_tag_in;
            r_rd_prev     <= r_init ? r_rd_q : host_rd_tag_in;
            r_word_q      <= host_word_in;
            eng_start_out <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_sync) begin
                        r_state <= ST_LOAD;
                        r_idx   <= '0;
                        err_out <= ERR_NONE;
                    end
                end
                ST_LOAD: begin
                    if (w_sync) begin
                        r_idx <= '0;
                    end else if (w_accept) begin
                        if (r_idx < c_idx_k) begin
                            for (int i = 0; i < DIM; i++) begin
                                if (r_idx == IW'(i)) r_coord[i] <= r_word_q;
                            end
                            r_idx <= r_idx + 1'b1;
                        end else if (r_idx == c_idx_k) begin
                            r_k_shadow <= r_word_q[15:0];
                            r_idx      <= r_idx + 1'b1;
                        end else begin
                            r_idx <= '0;
                            if (w_k_bad) begin
                                err_out <= ERR_BAD_K;
                                r_state <= ST_IDLE;
                            end else begin
                                eng_query_out <= r_coord;
                                eng_k_out     <= r_k_shadow;
                                eng_vid_out   <= r_word_q;
                                eng_start_out <= 1'b1;
                                busy_out      <= 1'b1;
                                r_state       <= ST_LAUNCH;
                            end
                        end
                    end
                end
                ST_LAUNCH: begin
                    cycles_out <= '0;
                    r_rd_ptr   <= '0;
                    r_state    <= ST_RUN;
                end
                ST_RUN: begin
                    cycles_out <= w_cycles_next;
                    if (w_res_drop) err_out <= ERR_OVERFLOW;
                    if (eng_done_in || w_timeout_hit) begin
                        if (!eng_done_in) err_out <= ERR_TIMEOUT;
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (w_sync) begin
                        r_idx    <= '0;
                        r_rd_ptr <= '0;
                        done_out <= 1'b0;
                        r_state  <= ST_LOAD;
                    end else if (w_rd_accept && (r_rd_ptr < res_count_out)) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                end
                default: begin
                    busy_out <= 1'b0;
                    done_out <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/query_sequencer.md
# query_sequencer

Host-to-engine sequencer for the graph-search datapath. Assembles one query (DIM coordinates, k, start vertex id) from a word-serial host mailbox, launches the search engine with a one-cycle start strobe, measures engine latency in cycles, captures up to k result ids in a local buffer, and serves them back to the host one word per read request. It sits between the UART debug mailbox and the search engine, replacing the ad-hoc load and collect logic in the top level.

## Interface
- DIM, 4: query dimensionality (number of coordinate words).
- K_MAX, 8: result buffer depth; the largest legal k.
- TIMEOUT_CYCLES, 32'd50_000_000: engine watchdog limit. Used only with QSEQ_TIMEOUT_EN.
- clk_in  input  1  system clock, 100 MHz.
- rst_n_in  input  1  asynchronous, active-low reset.
- host_word_in  input  32  host mailbox data word.
- host_tag_in  input  1  host toggles it once per new word; a change marks host_word_in valid.
- host_rd_tag_in  input  1  host toggles it to advance the result read pointer.
- eng_query_out  output  32 x [DIM]  query coordinates (unpacked array).
- eng_k_out  output  16  k for the engine.
- eng_vid_out  output  32  start vertex id.
- eng_start_out  output  1  one-cycle launch strobe.
- eng_result_in  input  32  engine result id.
- eng_result_valid_in  input  1  eng_result_in valid this cycle.
- eng_done_in  input  1  engine finished.
- res_data_out  output  32  current result word (0 when none).
- res_count_out  output  $clog2(K_MAX+1)  number of results captured.
- cycles_out  output  32  engine latency counter.
- busy_out  output  1  high in LAUNCH and RUN.
- done_out  output  1  high in DONE.
- err_out  output  2  sticky error code: 0 none, 1 bad k, 2 timeout, 3 result overflow.

## Operation
- SYNC_WORD = 32'hFFFF_FFFF. A word is accepted on any cycle where host_tag_in differs from its registered copy. There is no value-based deduplication, so a repeated value is a new word.
- The FSM states are IDLE, LOAD, LAUNCH, RUN and DONE.
- IDLE: on an accepted SYNC_WORD, go to LOAD, set idx=0 and clear err_out. Other words are ignored.
- LOAD: accepted words 0..DIM-1 go to coordinates, word DIM to k (low 16 bits), word DIM+1 to vid, and idx increments. An accepted SYNC_WORD inside LOAD resets idx to 0 (resync).
- LOAD exit after word DIM+1:
  - If k==0 or k>K_MAX, set err=1 and go to IDLE.
  - Otherwise go to LAUNCH.
- LAUNCH: eng_start_out=1 for exactly one cycle, cycles_out=0, buffer cleared. Go to RUN.
- RUN:
  - cycles_out increments each cycle and saturates at 32'hFFFF_FFFF.
  - Each eng_result_valid_in writes one entry while res_count_out<k.
  - Extra results are dropped and set err=3; the run continues.
  - eng_done_in goes to DONE. A result and done in the same cycle: the result is stored first.
  - Host words, including SYNC_WORD, are ignored in RUN.
- DONE:
  - res_data_out = buf[rd_ptr] while rd_ptr<res_count_out, else 0.
  - Each host_rd_tag_in toggle increments rd_ptr, saturating at res_count_out.
  - An accepted SYNC_WORD goes to LOAD with idx=0, rd_ptr=0 and count=0.
- eng_query_out, eng_k_out and eng_vid_out hold their values from the last completed load until the next completed load.
- host_rd_tag_in toggles outside DONE update the registered copy only.

## Timing
- Reset values: all outputs 0, state IDLE, idx=0, rd_ptr=0. The registered tags load the current input values on the first clock after reset release, so no spurious accept occurs.
- Accept latency: a tag change seen at edge N is stored at edge N+1.
- Final load word accepted at cycle N: LAUNCH and eng_start_out at N+1; RUN from N+2.
- cycles_out equals the number of RUN cycles up to and including the cycle eng_done_in is sampled. It is frozen in DONE.
- res_data_out is registered; it updates one cycle after a read toggle is accepted.
- Reset assertion mid-operation aborts immediately to IDLE with all outputs 0. It does not wait for the engine to finish.

## Configuration
- QSEQ_TIMEOUT_EN defined: in RUN, when cycles_out reaches TIMEOUT_CYCLES, set err=2 and go to DONE with whatever results are captured.
- QSEQ_TIMEOUT_EN undefined: no watchdog; RUN exits only on eng_done_in, and TIMEOUT_CYCLES is unused.

## Structure
- qseq_pkg holds:
  - the state enum;
  - SYNC_WORD;
  - error code constants (ERR_NONE, ERR_BAD_K, ERR_TIMEOUT, ERR_OVERFLOW).
- Sub-module qseq_result_buf: K_MAX x 32 register file with write pointer, count, clear, and registered read port. The top FSM owns the pointer policy.

## Test plan
- Load sequence SYNC, 5, 7, 1, 1, k=3, vid=0 (DIM=4), then engine emits results 10, 11, 12 and done 40 cycles after start -> one eng_start_out pulse; eng_query_out={5,7,1,1}; eng_k_out=3; cycles_out=40; three reads return 10, 11, 12, then 0.
- Load with k=0, and separately k=9 -> err_out=1; no start pulse; state IDLE.
- Engine emits 5 results with k=3 -> res_count_out=3; err_out=3; first three results stored.
- SYNC, 5, 7, SYNC, then a full sequence -> coordinates come from the post-resync words only.
- Same value sent twice via two tag toggles -> both words accepted. Reset asserted mid-RUN -> all outputs 0 at once.
- With QSEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, engine never done -> DONE after 100 RUN cycles; err_out=2.
